// File: rtl/i2s_master_ctrl.sv
// I2S master: derives sclk/lrclk from clk, captures the codec's stereo stream
// and hands left/right pairs to the DSP core over valid/ready with sticky overrun.
module i2s_master_ctrl #(
    parameter int SCLK_DIV    = 4,
    parameter int BITS_PER_CH = 32,
    parameter int DATA_W      = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sdin,
    output logic                     sclk,
    output logic                     lrclk,
    output logic signed [DATA_W-1:0] left,
    output logic signed [DATA_W-1:0] right,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     overrun,
    output logic                     running
);
    localparam int HALF_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int CNT_W  = $clog2(2 * BITS_PER_CH);

    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(2 * BITS_PER_CH - 1);
    localparam logic [CNT_W-1:0]  CH_BITS    = CNT_W'(BITS_PER_CH);
    localparam logic [CNT_W-1:0]  LAST_DATA  = CNT_W'(DATA_W);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [HALF_W-1:0] half_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_l;
    logic [DATA_W-1:0] shift_r;
    logic              pair_done;

    logic              half_tc;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              frame_wrap;
    logic [CNT_W-1:0]  bit_next;
    logic [CNT_W-1:0]  slot_pos;
    logic              data_slot;
    logic              xfer;

    assign running = (state == RUN);

    always_comb begin
        half_tc    = (state == RUN) && (half_cnt == HALF_LAST);
        sclk_rise  = half_tc && !sclk;
        sclk_fall  = half_tc && sclk;
        frame_wrap = sclk_fall && (bit_cnt == FRAME_LAST);
        bit_next   = frame_wrap ? '0 : bit_cnt + CNT_W'(1);
        // lrclk always equals (bit_cnt >= BITS_PER_CH), so it selects the slot offset
        slot_pos   = lrclk ? bit_cnt - CH_BITS : bit_cnt;
        data_slot  = (slot_pos != '0) && (slot_pos <= LAST_DATA);
        xfer       = sample_valid && sample_ready;
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            lrclk    <= 1'b0;
        end else if (state == IDLE) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            lrclk    <= 1'b0;
            if (en) state <= RUN;
        end else begin
            half_cnt <= half_tc ? '0 : half_cnt + HALF_W'(1);
            if (half_tc) sclk <= !sclk;
            if (sclk_fall) begin
                bit_cnt <= bit_next;
                lrclk   <= (bit_next >= CH_BITS);
                // Stop only on the frame boundary, so sclk is already falling low
                if (frame_wrap && !en) state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_l   <= '0;
            shift_r   <= '0;
            pair_done <= 1'b0;
        end else begin
            if (sclk_rise && data_slot) begin
                if (lrclk) shift_r <= {shift_r[DATA_W-2:0], sdin};
                else       shift_l <= {shift_l[DATA_W-2:0], sdin};
            end
            pair_done <= sclk_rise && lrclk && (slot_pos == LAST_DATA);
        end
    end

    // A new pair always wins; an unaccepted older pair is lost and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            left         <= '0;
            right        <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (pair_done) begin
            left         <= $signed(shift_l);
            right        <= $signed(shift_r);
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ready) overrun <= 1'b1;
        end else if (xfer) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Scoreboard bench for i2s_master_ctrl: codec models push expected pairs,
// monitors pop and compare whenever a pair is transferred.
module tb_i2s_master_ctrl;
    localparam logic [47:0] DEF_PAIR   = {24'h123456, 24'hFEDCBA};
    localparam logic [47:0] SMALL_PAIR = {24'hAAAAAA, 24'h555555};

    logic clk = 1'b0;
    logic rst, en, en_s, sample_ready, sample_ready_s;
    logic sdin = 1'b0;
    logic sdin_s = 1'b0;
    logic sclk, lrclk, sample_valid, overrun, running;
    logic sclk_s, lrclk_s, sample_valid_s, overrun_s, running_s;
    logic signed [23:0] left, right, left_s, right_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cnt     = 0;
    int cnt_s   = 0;
    int n_pairs = 0;
    int n_pairs_s = 0;
    logic prev_sclk = 1'b0;
    logic prev_sclk_s = 1'b0;
    logic [47:0] cur_pair = DEF_PAIR;
    logic [47:0] tx_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] exp_s_q[$];

    i2s_master_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .sdin(sdin), .sclk(sclk), .lrclk(lrclk),
        .left(left), .right(right), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun), .running(running)
    );

    i2s_master_ctrl #(.SCLK_DIV(1), .BITS_PER_CH(25), .DATA_W(24)) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .sdin(sdin_s), .sclk(sclk_s), .lrclk(lrclk_s),
        .left(left_s), .right(right_s), .sample_valid(sample_valid_s),
        .sample_ready(sample_ready_s), .overrun(overrun_s), .running(running_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cnt(input int v);
        int t = 0;
        while (cnt != v && t < 1300) begin
            tick();
            t++;
        end
        check("wait_bit_cnt", 64'(cnt == v), 64'(1));
    endtask

    // Codec slot bit: MSB first at slot positions 1..24, junk ones elsewhere.
    function automatic logic codec_bit(input int c, input int bpc, input logic [47:0] pair);
        int k;
        k = c % bpc;
        if (k < 1 || k > 24) return 1'b1;
        return (c >= bpc) ? pair[24 - k] : pair[48 - k];
    endfunction

    // Codec for the default instance: follows sclk falls with its own frame counter.
    always @(posedge clk) begin
        #1;
        if (!running) cnt = 0;
        else if (prev_sclk && !sclk) begin
            cnt = (cnt + 1) % 64;
            if (cnt == 1) begin
                if (tx_q.size() > 0) cur_pair = tx_q.pop_front();
                else cur_pair = DEF_PAIR;
            end
            sdin = codec_bit(cnt, 32, cur_pair);
            if (cnt == 56) exp_q.push_back(cur_pair);
            check("lrclk_slot", 64'(lrclk), 64'(cnt >= 32));
        end
        prev_sclk = sclk;
    end

    always @(posedge clk) begin
        #1;
        if (!running_s) cnt_s = 0;
        else if (prev_sclk_s && !sclk_s) begin
            cnt_s = (cnt_s + 1) % 50;
            sdin_s = codec_bit(cnt_s, 25, SMALL_PAIR);
            if (cnt_s == 49) exp_s_q.push_back(SMALL_PAIR);
        end
        prev_sclk_s = sclk_s;
    end

    always @(negedge clk) begin
        if (sample_valid && sample_ready) begin
            logic [47:0] e;
            n_pairs++;
            check("pair_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pair_left", 64'($unsigned(left)), 64'(e[47:24]));
                check("pair_right", 64'($unsigned(right)), 64'(e[23:0]));
            end
        end
        if (sample_valid_s && sample_ready_s) begin
            logic [47:0] e;
            n_pairs_s++;
            check("small_pair_expected", 64'(exp_s_q.size() > 0), 64'(1));
            if (exp_s_q.size() > 0) begin
                e = exp_s_q.pop_front();
                check("small_left", 64'($unsigned(left_s)), 64'(e[47:24]));
                check("small_right", 64'($unsigned(right_s)), 64'(e[23:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c0, c1, c2, c3, c4, c5, c6, c7, last, prev_pairs;
        logic stayed;
        rst = 1'b1; en = 1'b0; en_s = 1'b0; sample_ready = 1'b1; sample_ready_s = 1'b1;
        repeat (3) tick();
        check("rst_sclk", 64'(sclk), 64'(0));
        check("rst_lrclk", 64'(lrclk), 64'(0));
        check("rst_left", 64'($unsigned(left)), 64'(0));
        check("rst_right", 64'($unsigned(right)), 64'(0));
        check("rst_valid", 64'(sample_valid), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_running", 64'(running), 64'(0));
        check("rst_small_running", 64'(running_s), 64'(0));

        rst = 1'b0;
        tx_q.push_back(DEF_PAIR);
        tx_q.push_back({24'h800001, 24'h7FFFFE});
        tx_q.push_back({24'h000000, 24'hFFFFFF});
        repeat (2) tick();
        check("idle_running", 64'(running), 64'(0));
        check("idle_sclk", 64'(sclk), 64'(0));

        // Run entry and clock timing
        en = 1'b1; en_s = 1'b1;
        t = 0;
        while (!running && t < 5) begin tick(); t++; end
        check("run_entry_latency", 64'(t), 64'(1));
        c0 = cyc;
        t = 0;
        while (!sclk && t < 50) begin tick(); t++; end
        c1 = cyc;
        check("first_sclk_rise", 64'(c1 - c0), 64'(4));
        t = 0;
        while (sclk && t < 50) begin tick(); t++; end
        while (!sclk && t < 100) begin tick(); t++; end
        c2 = cyc;
        check("sclk_period", 64'(c2 - c1), 64'(8));
        t = 0;
        while (!lrclk && t < 600) begin tick(); t++; end
        c3 = cyc;
        while (lrclk && t < 1200) begin tick(); t++; end
        c4 = cyc;
        check("lrclk_half_frame", 64'(c4 - c3), 64'(256));
        wait_cnt(56);
        c5 = cyc;
        t = 0;
        while (!sample_valid && t < 50) begin tick(); t++; end
        c6 = cyc;
        check("valid_latency", 64'(c6 - c5), 64'(5));
        tick();
        check("valid_pulse", 64'(sample_valid), 64'(0));
        t = 0;
        while (!sample_valid && t < 1200) begin tick(); t++; end
        c7 = cyc;
        check("valid_spacing", 64'(c7 - c6), 64'(512));
        check("no_overrun_free_run", 64'(overrun), 64'(0));

        // Minimum-size instance: sclk period 2, frame 100
        t = 0;
        while (sclk_s && t < 10) begin tick(); t++; end
        while (!sclk_s && t < 10) begin tick(); t++; end
        c0 = cyc;
        tick();
        while (!sclk_s && t < 20) begin tick(); t++; end
        check("small_sclk_period", 64'(cyc - c0), 64'(2));
        t = 0;
        while (!sample_valid_s && t < 300) begin tick(); t++; end
        c0 = cyc;
        tick();
        while (!sample_valid_s && t < 600) begin tick(); t++; end
        check("small_frame_period", 64'(cyc - c0), 64'(100));

        // Overrun: two completions with ready low
        wait_cnt(60);
        sample_ready = 1'b0;
        tx_q.push_back({24'hA1B2C3, 24'h0F0F0F});
        tx_q.push_back({24'h5A5A5A, 24'h123ABC});
        t = 0;
        while (!overrun && t < 1300) begin tick(); t++; end
        check("overrun_set", 64'(overrun), 64'(1));
        check("overrun_left_b", 64'($unsigned(left)), 64'(24'h5A5A5A));
        check("overrun_right_b", 64'($unsigned(right)), 64'(24'h123ABC));
        check("overrun_queue_depth", 64'(exp_q.size()), 64'(2));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (3) tick();
        check("valid_held", 64'(sample_valid), 64'(1));
        sample_ready = 1'b1;
        tick();
        check("valid_drop_after_xfer", 64'(sample_valid), 64'(0));
        check("overrun_sticky", 64'(overrun), 64'(1));

        // Stop request sampled only at the frame wrap
        wait_cnt(10);
        en = 1'b0;
        last = cnt;
        t = 0;
        while (running && t < 700) begin last = cnt; tick(); t++; end
        check("stop_running", 64'(running), 64'(0));
        check("stop_at_wrap", 64'(last), 64'(63));
        check("stop_sclk", 64'(sclk), 64'(0));
        check("stop_lrclk", 64'(lrclk), 64'(0));
        check("stop_queue_drained", 64'(exp_q.size()), 64'(0));
        stayed = 1'b1;
        repeat (20) begin tick(); if (sclk || lrclk || running) stayed = 1'b0; end
        check("idle_quiet", 64'(stayed), 64'(1));
        en = 1'b1;
        tick();
        check("restart_running", 64'(running), 64'(1));

        // Deassert then reassert within one frame: no stop
        wait_cnt(10);
        en = 1'b0;
        wait_cnt(40);
        en = 1'b1;
        stayed = 1'b1;
        repeat (600) begin tick(); if (!running) stayed = 1'b0; end
        check("no_stop_on_reassert", 64'(stayed), 64'(1));

        // Reset mid-frame with en held high
        wait_cnt(30);
        rst = 1'b1;
        tick();
        check("midrst_sclk", 64'(sclk), 64'(0));
        check("midrst_lrclk", 64'(lrclk), 64'(0));
        check("midrst_left", 64'($unsigned(left)), 64'(0));
        check("midrst_right", 64'($unsigned(right)), 64'(0));
        check("midrst_valid", 64'(sample_valid), 64'(0));
        check("midrst_overrun", 64'(overrun), 64'(0));
        check("midrst_running", 64'(running), 64'(0));
        exp_q.delete();
        exp_s_q.delete();
        tx_q.delete();
        tx_q.push_back({24'h0ABCDE, 24'hF00F0F});
        rst = 1'b0;
        tick();
        check("rst_reentry", 64'(running), 64'(1));
        prev_pairs = n_pairs;
        t = 0;
        while (n_pairs == prev_pairs && t < 1200) begin tick(); t++; end
        check("pair_after_restart", 64'(n_pairs - prev_pairs), 64'(1));
        check("queue_empty_end", 64'(exp_q.size()), 64'(0));
        check("small_pairs_seen", 64'(n_pairs_s >= 3), 64'(1));
        check("small_no_overrun", 64'(overrun_s), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
